// File: rtl/mantissa_mul_seq.sv
// Iterative unsigned shift-add significand multiplier, start/done handshake, full 2*WIDTH product.
// Radix-2 by default (WIDTH cycles); define MANTISSA_MUL_RADIX4_EN for radix-4 (WIDTH/2 cycles, WIDTH even).
module mantissa_mul_seq #(
   parameter int WIDTH = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   operand_a,
   input  logic [WIDTH-1:0]   operand_b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

`ifdef MANTISSA_MUL_RADIX4_EN
   localparam int ACC_W    = WIDTH + 2;
   localparam int STEP     = 2;
   localparam int N_ITER   = WIDTH / 2;
`else
   localparam int ACC_W    = WIDTH + 1;
   localparam int STEP     = 1;
   localparam int N_ITER   = WIDTH;
`endif
   localparam int CW = (N_ITER > 1) ? $clog2(N_ITER) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(N_ITER - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 w_accept;
   logic                 w_last;

   logic [WIDTH-1:0]     r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [ACC_W-1:0]     r_acc;
   logic [CW-1:0]        r_count;
   logic [2*WIDTH-1:0]   r_product;
   logic                 r_done;

   logic [ACC_W-1:0]     w_addend;
   logic [ACC_W-1:0]     w_sum;
   logic [ACC_W+WIDTH-1:0] w_shift;

`ifdef MANTISSA_MUL_RADIX4_EN
   logic [ACC_W-1:0]     r_mcand3;

   always_comb begin
      w_addend = '0;
      case (r_mplier[1:0])
         2'd1:    w_addend = ACC_W'(r_mcand);
         2'd2:    w_addend = ACC_W'({r_mcand, 1'b0});
         2'd3:    w_addend = r_mcand3;
         default: w_addend = '0;
      endcase
   end
`else
   always_comb begin
      w_addend = r_mplier[0] ? ACC_W'(r_mcand) : '0;
   end
`endif

   // r_acc stays below 2^WIDTH between steps, so the sum never overflows ACC_W.
   assign w_sum   = r_acc + w_addend;
   assign w_shift = {w_sum, r_mplier} >> STEP;

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      busy        = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (r_count == '0) begin
               w_last      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_acc     <= '0;
         r_count   <= '0;
         r_product <= '0;
         r_done    <= 1'b0;
`ifdef MANTISSA_MUL_RADIX4_EN
         r_mcand3  <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_mcand  <= operand_a;
            r_mplier <= operand_b;
            r_acc    <= '0;
            r_count  <= CNT_INIT;
`ifdef MANTISSA_MUL_RADIX4_EN
            r_mcand3 <= ACC_W'(operand_a) + ACC_W'({operand_a, 1'b0});
`endif
         end else if (r_state == RUN) begin
            {r_acc, r_mplier} <= w_shift;
            r_count           <= r_count - CW'(1);
            if (w_last) begin
               r_product <= w_shift[2*WIDTH-1:0];
               r_done    <= 1'b1;
            end
         end
      end
   end

   assign done    = r_done;
   assign product = r_product;

endmodule

// File: tb/tb_mantissa_mul_seq.sv
// Directed-vector bench for mantissa_mul_seq: latency, busy window, hold, busy-ignore, back-to-back, reset.
module tb_mantissa_mul_seq;

   localparam int WIDTH = 24;
`ifdef MANTISSA_MUL_RADIX4_EN
   localparam int LAT = 12;
`else
   localparam int LAT = 24;
`endif

   logic               clk;
   logic               rst;
   logic               start;
   logic [WIDTH-1:0]   operand_a;
   logic [WIDTH-1:0]   operand_b;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] product;

   int n_checks;
   int n_errors;

   mantissa_mul_seq #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .busy      (busy),
      .done      (done),
      .product   (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive a start for one edge, then scramble the operand inputs.
   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      start     = 1'b1;
      operand_a = a;
      operand_b = b;
      step(1);
      start     = 1'b0;
      operand_a = 24'h5A5A5A;
      operand_b = 24'hA5A5A5;
   endtask

   task automatic wait_done(output int n, output bit busy_ok);
      n       = 0;
      busy_ok = 1'b1;
      while (done !== 1'b1 && n < 200) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         step(1);
         n++;
      end
   endtask

   task automatic count_done(input int cycles, output int pulses);
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         step(1);
         if (done === 1'b1) pulses++;
      end
   endtask

   task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [47:0] exp);
      int n;
      bit bok;
      issue(a, b);
      wait_done(n, bok);
      chk({tag, "_lat"}, 64'(n), 64'(LAT));
      chk({tag, "_busy_run"}, 64'(bok), 64'd1);
      chk({tag, "_busy_done"}, 64'(busy), 64'd0);
      chk({tag, "_prod"}, 64'(product), 64'(exp));
      step(1);
      chk({tag, "_done_fall"}, 64'(done), 64'd0);
      chk({tag, "_hold"}, 64'(product), 64'(exp));
   endtask

   initial begin
      int n;
      int pulses;
      bit bok;
      n_checks  = 0;
      n_errors  = 0;
      rst       = 1'b1;
      start     = 1'b0;
      operand_a = '0;
      operand_b = '0;
      step(3);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_prod", 64'(product), 64'd0);
      rst = 1'b0;
      step(2);

      run_op("half_sq", 24'h800000, 24'h800000, 48'h400000000000);
      run_op("c0_sq",   24'hC00000, 24'hC00000, 48'h900000000000);
      run_op("ones_sq", 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001);
      run_op("zero",    24'h000000, 24'hFFFFFF, 48'h000000000000);
      run_op("small",   24'h000003, 24'h000005, 48'h00000000000F);

      // A start while busy must not re-latch operands or add a second result.
      issue(24'h800000, 24'hC00000);
      step(4);
      issue(24'hFFFFFF, 24'hFFFFFF);
      wait_done(n, bok);
      chk("bsy_lat", 64'(n + 5), 64'(LAT));
      chk("bsy_prod", 64'(product), 64'h600000000000);
      count_done(LAT + 6, pulses);
      chk("bsy_single", 64'(pulses), 64'd0);
      chk("bsy_hold", 64'(product), 64'h600000000000);

      // Back-to-back: second start raised in the done cycle of the first.
      issue(24'h800000, 24'h800000);
      wait_done(n, bok);
      chk("b2b_prod1", 64'(product), 64'h400000000000);
      issue(24'h000001, 24'hABCDEF);
      chk("b2b_done_fall", 64'(done), 64'd0);
      chk("b2b_busy", 64'(busy), 64'd1);
      chk("b2b_hold1", 64'(product), 64'h400000000000);
      wait_done(n, bok);
      chk("b2b_lat", 64'(n), 64'(LAT));
      chk("b2b_hold_run", 64'(bok), 64'd1);
      chk("b2b_prod2", 64'(product), 64'h000000ABCDEF);
      step(1);

      // Reset mid-run discards the in-flight result.
      issue(24'hFFFFFF, 24'hFFFFFF);
      step(5);
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_done", 64'(done), 64'd0);
      chk("mid_rst_prod", 64'(product), 64'd0);
      count_done(LAT + 10, pulses);
      chk("mid_rst_nodone", 64'(pulses), 64'd0);
      chk("mid_rst_idle", 64'(busy), 64'd0);

      run_op("post_rst", 24'hC00000, 24'h800000, 48'h600000000000);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
